bus_timer: RTL

- Memory-mapped 16-bit interval timer that responds to accesses on the 65C02 core's bus.
- Decodes the address, captures write data, and returns registered read data with one cycle of latency, which is the synchronous-memory timing the core expects on DI.
- Drives the core's IRQ input on timeout.
- Sits beside RAM/ROM in the system top; the top-level DI mux selects `rd_data` when `sel` is high.

---
 rtl/bus_timer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit interval timer on the 65C02 core bus.
//
// Register block at BASE (AD[15:3] decode, AD[2:0] selects the register):
//   0  R: CNT[7:0]        W: LATCH[7:0]
//   1  R: CNT[15:8]       W: LATCH[15:8], then load CNT, start, clear IF
//   2  R/W: LATCH[7:0]
//   3  R/W: LATCH[15:8]   (no load, no start)
//   4  R/W: CTRL {ps, ie, cont, en}
//   5  R: STATUS {run, 000000, IF}   W: bit0=1 clears IF
//   6,7 read 0, writes ignored
//
// Read data is registered: a read hit in cycle n loads rd_data at edge n and
// raises sel for cycle n+1, matching the synchronous-memory DI timing.
//
// Optional build macro: BUS_TIMER_SNAPSHOT_EN
//   When defined, a read of offset 0 captures CNT[15:8] into a snapshot
//   register and offset-1 reads return that snapshot, so a low-then-high
//   byte read sequence sees one coherent 16-bit count.

module bus_timer #(
    parameter logic [15:0] BASE     = 16'hFE00,
    parameter int          PRESCALE = 8
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AD,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  rd_data,
    output logic        sel,
    output logic        IRQ
);

    // Terminal value of the prescaler; PRESCALE=256 maps onto 8'hFF.
    localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       hit;
    logic [2:0] off;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_stb;
    logic [7:0] rd_stb;

    assign hit   = (AD[15:3] == BASE[15:3]);
    assign off   = AD[2:0];
    assign wr_en = hit & WE;
    assign rd_en = hit & ~WE;

    // One strobe per register offset, for reads and for writes.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            assign wr_stb[gi] = wr_en && (off == 3'(gi));
            assign rd_stb[gi] = rd_en && (off == 3'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0] cnt_q,     cnt_d;
    logic [15:0] latch_q,   latch_d;
    logic [3:0]  ctrl_q,    ctrl_d;
    logic        if_q,      if_d;
    logic        run_q,     run_d;
    logic [7:0]  presc_q,   presc_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        sel_q,     sel_d;
`ifdef BUS_TIMER_SNAPSHOT_EN
    logic [7:0]  snap_q,    snap_d;
`endif

    // CTRL field aliases; all timing decisions use the registered CTRL so a
    // CTRL write only affects tick evaluation from the following cycle.
    logic ctrl_en;
    logic ctrl_cont;
    logic ctrl_ie;
    logic ctrl_ps;

    assign ctrl_en   = ctrl_q[0];
    assign ctrl_cont = ctrl_q[1];
    assign ctrl_ie   = ctrl_q[2];
    assign ctrl_ps   = ctrl_q[3];

    // ------------------------------------------------------------------
    // Tick generation
    // ------------------------------------------------------------------
    logic counting;
    logic presc_wrap;
    logic tick;
    logic expire;

    assign counting   = ctrl_en & run_q;
    assign presc_wrap = (presc_q == PRESC_LAST);
    assign tick       = counting & (~ctrl_ps | presc_wrap);
    assign expire     = tick & (cnt_q == 16'd0);

    // Next-state for counter, latch, control and flags, including the
    // priority between timer events and same-cycle bus writes.
    always_comb begin
        cnt_d   = cnt_q;
        latch_d = latch_q;
        ctrl_d  = ctrl_q;
        if_d    = if_q;
        run_d   = run_q;
        presc_d = presc_q;

        // Prescaler only advances in prescaled mode while the timer runs.
        if (counting && ctrl_ps) begin
            presc_d = presc_wrap ? 8'd0 : presc_q + 8'd1;
        end

        // Explicit IF clear comes first so a same-cycle expiry overrides it.
        if (wr_stb[5] && DO[0]) begin
            if_d = 1'b0;
        end

        // Count down; at zero flag the expiry and reload or stop. The
        // reload reads latch_q, so a same-cycle LATCH write is not seen.
        if (tick) begin
            if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
            end else begin
                if_d = 1'b1;
                if (ctrl_cont) begin
                    cnt_d = latch_q;
                end else begin
                    run_d = 1'b0;
                end
            end
        end

        // LATCH byte writes (offsets 0/2 low byte, 1/3 high byte).
        if (wr_stb[0] || wr_stb[2]) begin
            latch_d[7:0] = DO;
        end
        if (wr_stb[1] || wr_stb[3]) begin
            latch_d[15:8] = DO;
        end

        if (wr_stb[4]) begin
            ctrl_d = DO[3:0];
        end

        // Offset-1 write is the start command and beats any timer event.
        if (wr_stb[1]) begin
            cnt_d   = {DO, latch_q[7:0]};
            run_d   = 1'b1;
            if_d    = 1'b0;
            presc_d = 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [7:0] cnt_hi_rd;

`ifdef BUS_TIMER_SNAPSHOT_EN
    assign cnt_hi_rd = snap_q;

    // Capture the high count byte whenever the low byte is read.
    always_comb begin
        snap_d = snap_q;
        if (rd_stb[0]) begin
            snap_d = cnt_q[15:8];
        end
    end
`else
    assign cnt_hi_rd = cnt_q[15:8];
`endif

    // Select the register image for the addressed offset and hold rd_data
    // on anything other than a read hit.
    always_comb begin
        rd_data_d = rd_data_q;
        sel_d     = rd_en;
        if (rd_en) begin
            case (off)
                3'd0:    rd_data_d = cnt_q[7:0];
                3'd1:    rd_data_d = cnt_hi_rd;
                3'd2:    rd_data_d = latch_q[7:0];
                3'd3:    rd_data_d = latch_q[15:8];
                3'd4:    rd_data_d = {4'b0000, ctrl_q};
                3'd5:    rd_data_d = {run_q, 6'b000000, if_q};
                default: rd_data_d = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // State update with synchronous reset to the documented power-on values.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q     <= 16'hFFFF;
            latch_q   <= 16'hFFFF;
            ctrl_q    <= 4'h0;
            if_q      <= 1'b0;
            run_q     <= 1'b0;
            presc_q   <= 8'h00;
            rd_data_q <= 8'h00;
            sel_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            latch_q   <= latch_d;
            ctrl_q    <= ctrl_d;
            if_q      <= if_d;
            run_q     <= run_d;
            presc_q   <= presc_d;
            rd_data_q <= rd_data_d;
            sel_q     <= sel_d;
        end
    end

`ifdef BUS_TIMER_SNAPSHOT_EN
    // Snapshot register, reset to all ones like the counter it mirrors.
    always_ff @(posedge clk) begin
        if (RST) begin
            snap_q <= 8'hFF;
        end else begin
            snap_q <= snap_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_data = rd_data_q;
    assign sel     = sel_q;
    // Pure AND of two flops so IRQ cannot glitch; masking ie keeps IF.
    assign IRQ     = if_q & ctrl_ie;

endmodule
